// File: rtl/peripheral_bus.sv
// Memory-mapped timer, LED and 7-segment registers for the MEM stage of a simple CPU.
// Optional free-running SYSTICK counter is built only when PERIPH_SYSTICK_EN is defined.
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [11:0] digits
);

    localparam logic [29:0] OffTh      = 30'd0;
    localparam logic [29:0] OffTl      = 30'd1;
    localparam logic [29:0] OffTcon    = 30'd2;
    localparam logic [29:0] OffLed     = 30'd3;
    localparam logic [29:0] OffDigits  = 30'd4;
    localparam logic [29:0] OffSystick = 30'd5;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] dig_q, dig_d;
    logic [31:0] systick_val;

    logic [29:0] word_off;
    logic        sel_th, sel_tl, sel_tcon, sel_led, sel_dig, sel_systick;
    logic        overflow;
    logic        unused_addr_bits;

    // Byte lanes are irrelevant: decode on the word offset only. Addresses below
    // BASE_ADDR wrap to a large offset and so fall into the unmapped default.
    assign word_off         = address[31:2] - BASE_ADDR[31:2];
    assign unused_addr_bits = ^address[1:0];

    always_comb begin
        sel_th      = 1'b0;
        sel_tl      = 1'b0;
        sel_tcon    = 1'b0;
        sel_led     = 1'b0;
        sel_dig     = 1'b0;
        sel_systick = 1'b0;
        case (word_off)
            OffTh:      sel_th      = 1'b1;
            OffTl:      sel_tl      = 1'b1;
            OffTcon:    sel_tcon    = 1'b1;
            OffLed:     sel_led     = 1'b1;
            OffDigits:  sel_dig     = 1'b1;
            OffSystick: sel_systick = 1'b1;
            default:    ;
        endcase
    end

    assign overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        dig_d  = dig_q;

        if (tcon_q[0]) begin
            if (overflow) begin
                tl_d = th_q;
                if (tcon_q[1]) begin
                    tcon_d[2] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        // CPU writes override the timer's own update for the same register.
        if (MemWrite) begin
            if (sel_th) begin
                th_d = write_data;
            end
            if (sel_tl) begin
                tl_d = write_data;
            end
            if (sel_tcon) begin
                tcon_d = write_data[2:0];
                if (overflow && !write_data[0]) begin
                    tl_d = tl_q;
                end
            end
            if (sel_led) begin
                led_d = write_data[7:0];
            end
            if (sel_dig) begin
                dig_d = write_data[11:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            tcon_q <= 3'd0;
            led_q  <= 8'd0;
            dig_q  <= 12'd0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            dig_q  <= dig_d;
        end
    end

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_q, systick_d;

    assign systick_d = systick_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            systick_q <= 32'd0;
        end else begin
            systick_q <= systick_d;
        end
    end

    assign systick_val = systick_q;
`else
    assign systick_val = 32'd0;
`endif

    always_comb begin
        read_data = 32'd0;
        if (MemRead) begin
            if (sel_th) begin
                read_data = th_q;
            end else if (sel_tl) begin
                read_data = tl_q;
            end else if (sel_tcon) begin
                read_data = {29'd0, tcon_q};
            end else if (sel_led) begin
                read_data = {24'd0, led_q};
            end else if (sel_dig) begin
                read_data = {20'd0, dig_q};
            end else if (sel_systick) begin
                read_data = systick_val;
            end
        end
    end

    assign irq    = tcon_q[1] & tcon_q[2];
    assign leds   = led_q;
    assign digits = dig_q;

endmodule

// File: tb/tb_peripheral_bus.sv
// Directed and randomized checks of peripheral_bus against a register-level reference model.
// Honours PERIPH_SYSTICK_EN in the same way as the design.
module tb_peripheral_bus;

    localparam logic [31:0] Base = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        irq;
    logic [7:0]  leds;
    logic [11:0] digits;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [31:0] m_th = 0, m_tl = 0, m_systick = 0;
    logic [2:0]  m_tcon = 0;
    logic [7:0]  m_led = 0;
    logic [11:0] m_dig = 0;

    peripheral_bus #(.BASE_ADDR(Base)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .irq        (irq),
        .leds       (leds),
        .digits     (digits)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
        logic [31:0] off;
        off = (a & 32'hFFFF_FFFC) - Base;
        if (!rd) return 32'd0;
        case (off)
            32'h00:  return m_th;
            32'h04:  return m_tl;
            32'h08:  return {29'd0, m_tcon};
            32'h0C:  return {24'd0, m_led};
            32'h10:  return {20'd0, m_dig};
`ifdef PERIPH_SYSTICK_EN
            32'h14:  return m_systick;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the architectural rules: timer first, then the CPU write on top.
    task automatic model_edge(input logic rst, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd);
        logic [31:0] off, n_tl;
        logic [2:0]  n_tcon;
        logic        ovf;
        if (rst) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_dig = 0; m_systick = 0;
            return;
        end
        off    = (a & 32'hFFFF_FFFC) - Base;
        ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        n_tl   = m_tcon[0] ? (ovf ? m_th : m_tl + 1) : m_tl;
        n_tcon = m_tcon;
        if (ovf && m_tcon[1]) n_tcon[2] = 1'b1;
        if (wr) begin
            case (off)
                32'h04: n_tl = wd;
                32'h08: begin
                    n_tcon = wd[2:0];
                    if (ovf && !wd[0]) n_tl = m_tl;
                end
                32'h0C: m_led = wd[7:0];
                32'h10: m_dig = wd[11:0];
                default: ;
            endcase
            if (off == 32'h00) m_th = wd;
        end
        m_tl      = n_tl;
        m_tcon    = n_tcon;
        m_systick = m_systick + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs (called just after a falling edge), check outputs, clock it.
    task automatic step(input logic rst, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
        reset = rst; MemRead = rd; MemWrite = wr; address = a; write_data = wd;
        #1;
        if (!rst) begin
            check("read_data", read_data, m_read(rd, a));
            check("irq", {31'd0, irq}, {31'd0, m_tcon[1] & m_tcon[2]});
            check("leds", {24'd0, leds}, {24'd0, m_led});
            check("digits", {20'd0, digits}, {20'd0, m_dig});
        end
        @(posedge clk);
        model_edge(rst, wr, a, wd);
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] wd);
        step(1'b0, 1'b0, 1'b1, Base + off, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, Base, 32'd0);
    endtask

    // Read with a hand-derived expectation, then run the cycle with the model checks too.
    task automatic read_is(input string tag, input logic [31:0] a, input logic [31:0] exp);
        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; address = a; write_data = 32'd0;
        #1;
        check(tag, read_data, exp);
        step(1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask

    initial begin
        logic [31:0] a, wd, off;
        logic        rd, wr, rst;
        int          r;

        @(negedge clk);
        // Reset with a concurrent write: reset wins.
        step(1'b1, 1'b0, 1'b1, Base + 32'h0C, 32'hFF);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_leds", {24'd0, leds}, 32'd0);
        check("rst_digits", {20'd0, digits}, 32'd0);
        read_is("rst_systick", Base + 32'h14, 32'd0);
        for (int i = 0; i < 5; i++) read_is("rst_reg", Base + 32'(i * 4), 32'd0);

        // Reload: overflow reloads TH and raises the interrupt.
        wr_reg(32'h00, 32'hFFFF_FFFC);
        wr_reg(32'h04, 32'hFFFF_FFFE);
        wr_reg(32'h08, 32'h3);
        idle(2);
        read_is("reload_tl", Base + 32'h04, 32'hFFFF_FFFC);
        read_is("reload_tcon", Base + 32'h08, 32'h7);
        check("reload_irq_set", {31'd0, irq}, 32'd1);
        wr_reg(32'h08, 32'h3);
        check("reload_irq_clr", {31'd0, irq}, 32'd0);
        // TL is now all-ones: clearing enable on the overflow edge freezes TL.
        wr_reg(32'h08, 32'h0);
        read_is("tcon_off_tl_hold", Base + 32'h04, 32'hFFFF_FFFF);

        // CPU write to TL on the overflow edge wins over the reload.
        wr_reg(32'h08, 32'h3);
        wr_reg(32'h04, 32'h0000_0010);
        read_is("collide_tl", Base + 32'h04, 32'h0000_0010);
        read_is("collide_tcon", Base + 32'h08, 32'h7);

        // CPU write to TCON on the overflow edge drops the status set; TL still reloads.
        wr_reg(32'h08, 32'h3);
        wr_reg(32'h04, 32'hFFFF_FFFF);
        wr_reg(32'h08, 32'h3);
        read_is("tcon_win_tl", Base + 32'h04, 32'hFFFF_FFFC);
        read_is("tcon_win_tcon", Base + 32'h08, 32'h3);

        // TH written on the reload edge: reload uses the old TH.
        wr_reg(32'h04, 32'hFFFF_FFFF);
        wr_reg(32'h00, 32'h0000_0055);
        read_is("th_old_reload", Base + 32'h04, 32'hFFFF_FFFC);
        read_is("th_new", Base + 32'h00, 32'h0000_0055);
        wr_reg(32'h08, 32'h0);

        // Decode.
        wr_reg(32'h0C, 32'h1A5);
        check("led_write", {24'd0, leds}, 32'hA5);
        wr_reg(32'h10, 32'hFFFF);
        check("dig_write", {20'd0, digits}, 32'hFFF);
        wr_reg(32'h18, 32'hDEAD_BEEF);
        read_is("unmapped_rd", Base + 32'h18, 32'd0);
        read_is("below_base_rd", Base - 32'h4, 32'd0);
        read_is("led_after_unmapped", Base + 32'h0C, 32'hA5);
        read_is("dig_after_unmapped", Base + 32'h10, 32'hFFF);
        read_is("low_bits_ignored", Base + 32'h0F, 32'hA5);
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; address = Base + 32'h0C;
        #1;
        check("memread_low", read_data, 32'd0);
        // Read and write together: read returns the old contents.
        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b1; address = Base + 32'h0C;
        write_data = 32'h3C;
        #1;
        check("rw_same_cycle", read_data, 32'hA5);
        step(1'b0, 1'b1, 1'b1, Base + 32'h0C, 32'h3C);
        check("rw_led_updated", {24'd0, leds}, 32'h3C);

        // Systick: count non-reset edges since reset; writes ignored.
        step(1'b1, 1'b0, 1'b0, Base, 32'd0);
        wr_reg(32'h14, 32'h1234);
        idle(99);
`ifdef PERIPH_SYSTICK_EN
        read_is("systick_100", Base + 32'h14, 32'd100);
`else
        read_is("systick_absent", Base + 32'h14, 32'd0);
`endif

        // Randomized traffic, biased toward timer overflows.
        wr_reg(32'h00, 32'hFFFF_FFF0);
        for (int i = 0; i < 600; i++) begin
            r   = int'($urandom_range(0, 7));
            off = (r == 7) ? 32'hFFFF_FFFC : 32'(r * 4);
            a   = Base + off + 32'($urandom_range(0, 3));
            rd  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 9) < 3);
            rst = ($urandom_range(0, 199) == 0);
            wd  = $urandom;
            if (off == 32'h04 && wd[0]) wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (off == 32'h08 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            step(rst, rd, wr, a, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
